// File: rtl/vespa_fetch_unit.sv
// Instruction fetch stage: drives a hold-until-ready instruction memory port and
// feeds the fetch/decode register through a one-entry skid buffer with branch redirect.
module vespa_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Stall,
    input  logic        i_BranchTaken,
    input  logic [31:0] i_BranchTarget,
    output logic        o_IMemReq,
    output logic [31:0] o_IMemAddr,
    input  logic        i_IMemReady,
    input  logic [31:0] i_IMemData,
    output logic [31:0] o_InstructionRegister,
    output logic [31:0] o_ProgramCounter,
    output logic        o_Valid
);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_KILL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_ir_q, hold_ir_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic [31:0] target;
    logic [31:0] fetch_pc_plus4;

    assign target         = i_BranchTarget & ~32'd3;
    assign fetch_pc_plus4 = fetch_pc_q + 32'd4;

    always_comb begin
        state_d               = state_q;
        fetch_pc_d            = fetch_pc_q;
        hold_ir_d             = hold_ir_q;
        hold_pc_d             = hold_pc_q;
        redir_pc_d            = redir_pc_q;
        o_IMemReq             = 1'b0;
        o_IMemAddr            = fetch_pc_q;
        o_Valid               = 1'b0;
        o_InstructionRegister = '0;
        o_ProgramCounter      = '0;

        // Outputs stay quiet while reset is asserted; state is reset in the flops.
        if (!i_Rst) begin
            case (state_q)
                S_REQ: begin
                    o_IMemReq = 1'b1;
                    if (i_BranchTaken) begin
                        if (i_IMemReady) begin
                            fetch_pc_d = target;
                        end else begin
                            redir_pc_d = target;
                            state_d    = S_KILL;
                        end
                    end else if (i_IMemReady) begin
                        o_Valid               = 1'b1;
                        o_InstructionRegister = i_IMemData;
                        o_ProgramCounter      = fetch_pc_plus4;
                        fetch_pc_d            = fetch_pc_plus4;
                        if (i_Stall) begin
                            hold_ir_d = i_IMemData;
                            hold_pc_d = fetch_pc_plus4;
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_BranchTaken) begin
                        fetch_pc_d = target;
                        state_d    = S_REQ;
                    end else begin
                        o_Valid               = 1'b1;
                        o_InstructionRegister = hold_ir_q;
                        o_ProgramCounter      = hold_pc_q;
                        if (!i_Stall) begin
                            state_d = S_REQ;
                        end
                    end
                end
                S_KILL: begin
                    // The stale request must complete before the redirect can be issued.
                    o_IMemReq = 1'b1;
                    if (i_BranchTaken) begin
                        redir_pc_d = target;
                    end
                    if (i_IMemReady) begin
                        fetch_pc_d = i_BranchTaken ? target : redir_pc_q;
                        state_d    = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_VECTOR;
            hold_ir_q  <= '0;
            hold_pc_q  <= '0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            hold_ir_q  <= hold_ir_d;
            hold_pc_q  <= hold_pc_d;
            redir_pc_q <= redir_pc_d;
        end
    end

endmodule

// File: tb/tb_vespa_fetch_unit.sv
// Bench for vespa_fetch_unit: directed scenarios, then random traffic checked
// against a program-order instruction stream model via a scoreboard queue.
module tb_vespa_fetch_unit;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, branch, ready;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr, imem_data, ir, pc;
    logic        valid;
    logic        use_fixed;
    logic [31:0] fixed_data;

    logic        req2, valid2;
    logic [31:0] addr2, ir2, pc2, data2;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned n_consumed = 0;
    logic        rand_on = 1'b0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_data = use_fixed ? fixed_data : mem_word(imem_addr);
    assign data2     = mem_word(addr2);

    vespa_fetch_unit dut (
        .i_Clk                 (clk),
        .i_Rst                 (rst),
        .i_Stall               (stall),
        .i_BranchTaken         (branch),
        .i_BranchTarget        (target),
        .o_IMemReq             (imem_req),
        .o_IMemAddr            (imem_addr),
        .i_IMemReady           (ready),
        .i_IMemData            (imem_data),
        .o_InstructionRegister (ir),
        .o_ProgramCounter      (pc),
        .o_Valid               (valid)
    );

    vespa_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
        .i_Clk                 (clk),
        .i_Rst                 (rst),
        .i_Stall               (1'b0),
        .i_BranchTaken         (1'b0),
        .i_BranchTarget        (32'h0),
        .o_IMemReq             (req2),
        .o_IMemAddr            (addr2),
        .i_IMemReady           (req2),
        .i_IMemData            (data2),
        .o_InstructionRegister (ir2),
        .o_ProgramCounter      (pc2),
        .o_Valid               (valid2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares consumed instructions against the scoreboard and checks protocol rules.
    initial begin
        logic        have_prev;
        logic        prev_req, prev_ready;
        logic [31:0] prev_addr;
        exp_t        e;
        have_prev = 1'b0;
        prev_req = 1'b0;
        prev_ready = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rand_on) begin
                have_prev = 1'b0;
                continue;
            end
            if (rst) begin
                chk("rnd_rst_req", imem_req, 1'b0);
                chk("rnd_rst_valid", valid, 1'b0);
                have_prev = 1'b0;
                continue;
            end
            if (have_prev && prev_req && !prev_ready) begin
                chk("rnd_req_kept", imem_req, 1'b1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            if (imem_req) chk("rnd_addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
            if (branch) chk("rnd_branch_invalid", valid, 1'b0);
            if (!valid) begin
                chk("rnd_nop_ir", ir, 32'h0);
                chk("rnd_nop_pc", pc, 32'h0);
            end else if (!stall) begin
                if (sb.size() == 0) begin
                    chk("rnd_sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_consumed++;
                    chk("rnd_ir", ir, e.ir);
                    chk("rnd_pc", pc, e.pc);
                end
            end
            prev_req   = imem_req;
            prev_ready = ready;
            prev_addr  = imem_addr;
            have_prev  = 1'b1;
        end
    end

    initial begin
        logic [31:0] exp2 [3];
        logic [31:0] seq_pc, tgt_prev;
        logic        rst_prev, br_prev;

        exp2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        rst = 1'b1; stall = 1'b0; branch = 1'b0; ready = 1'b0; target = '0;
        use_fixed = 1'b0; fixed_data = '0;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req2", req2, 1'b0);

        // Zero-wait streaming, plus wrap-around from a high reset vector
        tick();
        rst = 1'b0; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("zw_addr", imem_addr, 32'(4 * k));
            chk("zw_pc", pc, 32'(4 * k + 4));
            chk("zw_valid", valid, 1'b1);
            chk("zw_ir", ir, mem_word(32'(4 * k)));
            if (k < 3) chk("rv_addr", addr2, exp2[k]);
            if (k == 2) chk("rv_wrap_pc", pc2, 32'h4);
            tick();
        end

        // Stall holds a fetched word in the skid buffer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        use_fixed = 1'b1; fixed_data = 32'hA5A5_0001; stall = 1'b1;
        @(negedge clk);
        chk("st_addr", imem_addr, 32'h8);
        chk("st_valid", valid, 1'b1);
        chk("st_ir", ir, 32'hA5A5_0001);
        chk("st_pc", pc, 32'hC);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("hold_req", imem_req, 1'b0);
            chk("hold_ir", ir, 32'hA5A5_0001);
            chk("hold_pc", pc, 32'hC);
            chk("hold_valid", valid, 1'b1);
        end
        tick();
        stall = 1'b0; use_fixed = 1'b0;
        @(negedge clk);
        chk("rel_valid", valid, 1'b1);
        chk("rel_pc", pc, 32'hC);
        chk("rel_req", imem_req, 1'b0);
        tick();
        @(negedge clk);
        chk("rel_next_req", imem_req, 1'b1);
        chk("rel_next_addr", imem_addr, 32'hC);

        // Branch while a request waits
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("br_addr0", imem_addr, 32'h0);
        tick();
        ready = 1'b0; branch = 1'b1; target = 32'h0000_0103;
        @(negedge clk);
        chk("br_addr4", imem_addr, 32'h4);
        chk("br_valid", valid, 1'b0);
        tick();
        branch = 1'b0;
        @(negedge clk);
        chk("kill_addr_a", imem_addr, 32'h4);
        chk("kill_req_a", imem_req, 1'b1);
        chk("kill_valid_a", valid, 1'b0);
        tick();
        ready = 1'b1;
        @(negedge clk);
        chk("kill_addr_b", imem_addr, 32'h4);
        chk("kill_valid_b", valid, 1'b0);
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_pc", pc, 32'h104);

        // Branch while holding a stalled word
        tick();
        branch = 1'b1; target = 32'h200;
        @(negedge clk);
        chk("hbr_valid", valid, 1'b0);
        chk("hbr_req", imem_req, 1'b0);
        tick();
        branch = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("hbr_addr", imem_addr, 32'h200);
        chk("hbr_pc", pc, 32'h204);

        // Reset while killing, with a response in the same cycle
        tick();
        ready = 1'b0; branch = 1'b1; target = 32'h300;
        @(negedge clk);
        tick();
        branch = 1'b0; rst = 1'b1; ready = 1'b1;
        @(negedge clk);
        chk("krst_req", imem_req, 1'b0);
        chk("krst_valid", valid, 1'b0);
        chk("krst_ir", ir, 32'h0);
        chk("krst_pc", pc, 32'h0);
        tick();
        rst = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk("krst_next_req", imem_req, 1'b1);
        chk("krst_next_addr", imem_addr, 32'h0);

        // Random traffic against the program-order stream model
        tick();
        rst = 1'b1; stall = 1'b0; branch = 1'b0;
        rst_prev = 1'b1; br_prev = 1'b0; tgt_prev = '0; seq_pc = '0;
        tick();
        rand_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (rst_prev) begin
                sb.delete();
                seq_pc = 32'h0;
            end else if (br_prev) begin
                sb.delete();
                seq_pc = tgt_prev & ~32'd3;
            end
            while (sb.size() < 4) begin
                sb.push_back('{ir: mem_word(seq_pc), pc: seq_pc + 32'd4});
                seq_pc = seq_pc + 32'd4;
            end
            rst    = ($urandom_range(0, 199) == 0);
            ready  = ($urandom_range(0, 9) < 7);
            stall  = ($urandom_range(0, 9) < 3);
            branch = !rst && ($urandom_range(0, 99) < 8);
            target = $urandom;
            if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 | (target & 32'hF);
            rst_prev = rst; br_prev = branch; tgt_prev = target;
            tick();
        end
        rand_on = 1'b0;
        chk("rnd_progress", {31'b0, n_consumed > 300}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vespa_fetch_unit.md
VESPA_FETCH_UNIT -- requirements
Module: vespa_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 i_Clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_Rst  input  1  reset, synchronous, active-high.
REQ-004 i_Stall  input  1  downstream fetch/decode register is holding; the fetched instruction is not consumed this cycle.
REQ-005 i_BranchTaken  input  1  redirect request from a later stage.
REQ-006 i_BranchTarget  input  32  redirect address; bits [1:0] ignored and treated as 00.
REQ-007 o_IMemReq  output  1  instruction memory request.
REQ-008 o_IMemAddr  output  32  word-aligned fetch address.
REQ-009 i_IMemReady  input  1  memory returns i_IMemData for the current request this cycle.
REQ-010 i_IMemData  input  32  instruction word.
REQ-011 o_InstructionRegister  output  32  instruction to the fetch/decode register; 32'h0 (NOP) when o_Valid=0.
REQ-012 o_ProgramCounter  output  32  fetch address of the presented instruction + 4; 0 when o_Valid=0.
REQ-013 o_Valid  output  1  o_InstructionRegister/o_ProgramCounter carry a real instruction.

Function
REQ-014 Internal state: FetchPC (32b), HoldIR/HoldPC (32b each, one-entry skid buffer), RedirPC (32b), FSM {S_REQ, S_HOLD, S_KILL}.
REQ-015 Memory protocol: once o_IMemReq=1, o_IMemAddr SHALL remain stable until the cycle i_IMemReady=1; requests are never withdrawn.
REQ-016 S_REQ: o_IMemReq=1, o_IMemAddr=FetchPC.
REQ-017 S_REQ, i_IMemReady=0, i_BranchTaken=0: no state change, o_Valid=0; i_Stall has no effect.
REQ-018 S_REQ, i_IMemReady=0, i_BranchTaken=1: RedirPC<=target, go S_KILL.
REQ-019 S_REQ, i_IMemReady=1, i_BranchTaken=1: data discarded, o_Valid=0, FetchPC<=target, stay S_REQ.
REQ-020 S_REQ, i_IMemReady=1, no branch, i_Stall=0: combinationally present i_IMemData, FetchPC+4, o_Valid=1; FetchPC<=FetchPC+4; stay S_REQ (zero-wait memory gives one instruction per cycle).
REQ-021 S_REQ, i_IMemReady=1, no branch, i_Stall=1: present the word with o_Valid=1, HoldIR<=data, HoldPC<=FetchPC+4, FetchPC<=FetchPC+4, go S_HOLD.
REQ-022 S_HOLD: o_IMemReq=0, outputs driven from HoldIR/HoldPC with o_Valid=1.
REQ-023 S_HOLD, i_BranchTaken=1 (priority over i_Stall): buffer dropped, o_Valid=0, FetchPC<=target, go S_REQ.
REQ-024 S_HOLD, i_Stall=0: buffered instruction consumed this cycle, go S_REQ; i_Stall=1: remain.
REQ-025 S_KILL: o_IMemReq=1 with the old address, o_Valid=0; i_BranchTaken=1 overwrites RedirPC (latest wins); on i_IMemReady=1 data dropped, FetchPC<=RedirPC (or the same-cycle target if a branch arrives then), go S_REQ.
REQ-026 FetchPC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-027 No instruction is presented twice with o_Valid=1 unless i_Stall was high in the preceding cycle; no instruction is lost.

Reset
REQ-028 While i_Rst=1: FetchPC<=RESET_VECTOR, FSM<=S_REQ, HoldIR/HoldPC/RedirPC<=0, o_IMemReq=0, o_Valid=0, o_InstructionRegister=0, o_ProgramCounter=0.
REQ-029 Reset mid-transaction (S_KILL or S_REQ waiting) abandons the request; a response arriving in the reset cycle is ignored; first post-reset request targets RESET_VECTOR.

Verification
REQ-030 Reset, zero-wait memory, i_Stall=0 -> o_IMemAddr 0,4,8,12 on consecutive cycles; o_ProgramCounter 4,8,12,16; o_Valid=1 each cycle.
REQ-031 Memory returns 32'hA5A5_0001 at addr 8 with i_Stall=1 for 3 cycles -> o_IMemReq=0 for those cycles, outputs hold A5A5_0001/12; after release next request to addr 12.
REQ-032 Branch to 32'h0000_0103 while addr 4 request waits 2 cycles -> addr 4 held until ready, its data dropped (o_Valid=0), next request addr 32'h100.
REQ-033 Branch during S_HOLD with i_Stall=1 -> o_Valid=0 that cycle, next request at target.
REQ-034 RESET_VECTOR=32'hFFFF_FFF8, zero-wait -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 i_Rst asserted in S_KILL with i_IMemReady=1 same cycle -> all outputs 0, next cycle request at RESET_VECTOR.
